ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset.
//  Drives the open-drain PS/2 CLK/DAT pins through output-enables, and the top level builds the tri-states.
//  Sits beside the PS/2 receiver and scancode converter. cmd_busy tells the receive path to ignore bus activity.
// PARAMETERS
//  INHIBIT_CYCLES  5000    CLOCK_50 cycles that CLK is held low before request-to-send (100 us)
//  TIMEOUT_CYCLES  750000  max CLOCK_50 cycles without a device CLK falling edge before abort (15 ms)
// PORTS
//  CLOCK_50     in   1  system clock, all logic on posedge
//  resetn       in   1  asynchronous, active-low reset
//  cmd_byte     in   8  byte to send; sampled when cmd_send is accepted
//  cmd_send     in   1  request strobe; accepted only in IDLE
//  ps2_clk_in   in   1  raw PS/2 CLK pin level (asynchronous)
//  ps2_dat_in   in   1  raw PS/2 DAT pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull CLK low; 0 = release
//  ps2_dat_oe   out  1  1 = pull DAT low; 0 = release
//  cmd_busy     out  1  high from acceptance until return to IDLE
//  cmd_done     out  1  1-cycle pulse: byte sent and device ACK seen
//  cmd_error    out  1  1-cycle pulse: no ACK or timeout
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE; every output is 0, so both lines are released.
//    Reset mid-frame releases both lines at once. No done or error pulse is produced.
//  - Input sync: ps2_clk_in and ps2_dat_in each pass through 2 flops.
//    fall = (clk_sync_prev==1 && clk_sync==0). All bit actions occur on the cycle fall is seen.
//  - Frame buffer: {stop=1, parity, cmd_byte[7:0]}, sent LSB first.
//    parity = ~^cmd_byte (odd parity). Bit counter is 4 bits, range 0..9.
//  - State IDLE: busy=0, clk_oe=0, dat_oe=0.
//    On cmd_send=1: latch byte, clear counters, go INHIBIT. The next cycle has busy=1 and clk_oe=1.
//  - State INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. Then dat_oe=1 (start bit), clk_oe=0, go RTS.
//  - State RTS: wait for the first fall. On it, present bit0 (dat_oe = ~bit0) and go DATA with idx=1.
//  - State DATA: on each fall, present buffer bit idx (dat_oe = ~bit) and increment idx.
//    Order: bit0..7, parity, then stop (dat_oe=0).
//    After the fall that presents stop (10th fall overall), go ACK.
//  - State ACK: on the next fall, sample dat_sync. 0 means ACK: go WAIT_IDLE.
//    1 means no ACK: pulse cmd_error and go IDLE.
//  - State WAIT_IDLE: wait until clk_sync=1 and dat_sync=1. Then pulse cmd_done and go IDLE.
//  - Timeout: a counter runs in RTS, DATA, ACK and WAIT_IDLE. It clears on every fall.
//    When it reaches TIMEOUT_CYCLES: pulse cmd_error, release both lines, go IDLE.
//    If a fall coincides with the terminal count, the fall wins.
//  - cmd_send while busy is ignored; it is not queued.
//    cmd_send in the same cycle as the done or error pulse is also ignored. It is accepted from the next cycle in IDLE.
//  - cmd_done and cmd_error are mutually exclusive. They assert together with the return to IDLE, and cmd_busy falls on that same edge.
//  - cmd_byte changes after acceptance have no effect.
// TESTING (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, behavioural device model ~12 kHz CLK)
//  1. Send 0xED, device ACKs -> CLK held low 20 cycles, start bit 0.
//     Data sampled on CLK rise = 1,0,1,1,0,1,1,1; parity=1, stop=1.
//     Then one cmd_done pulse, cmd_busy=0, both oe=0.
//  2. Send 0x01 and then 0xFF back-to-back, both ACKed -> parity 0 for 0x01, parity 1 for 0xFF.
//     Two cmd_done pulses and no error.
//  3. Send 0xF4, device leaves DAT high at the ACK edge -> cmd_error pulse, no cmd_done, lines released.
//  4. Device never clocks after RTS -> cmd_error exactly 200 cycles after entering RTS.
//     ps2_dat_oe=0 on the following cycle.
//  5. resetn low after the 5th data bit -> both oe=0 asynchronously with no pulses.
//     A fresh 0xED then completes normally.
//  6. cmd_send=1 with cmd_byte=0xAA pulsed mid-frame while sending 0xED -> the 0xED frame is unchanged.
//     Exactly one cmd_done, and 0xAA is never transmitted.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, shifts one
// command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_send,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_DATA      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t        state_q, state_d;
    logic [9:0]    buf_q, buf_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall_s, tmo_hit_s, abort_s;

    // Two-flop synchronisers; idle bus level is high, so reset to 1 to avoid a false fall.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall_s    = clk_prev_q & ~clk_sync_q;
    // A fall on the terminal count clears the counter instead of aborting.
    assign tmo_hit_s = (cnt_q == TMO_LAST) & ~fall_s;

    // Next-state, frame shifting and output computation.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        abort_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                // A request coinciding with the done/error pulse is dropped.
                if (cmd_send && !done_q && !error_q) begin
                    buf_d    = {1'b1, odd_parity(cmd_byte), cmd_byte};
                    idx_d    = 4'd0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RTS: begin
                if (fall_s) begin
                    dat_oe_d = ~buf_q[0];
                    idx_d    = 4'd1;
                    cnt_d    = '0;
                    state_d  = S_DATA;
                end else if (tmo_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (fall_s) begin
                    dat_oe_d = ~buf_q[idx_q];
                    cnt_d    = '0;
                    if (idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (tmo_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACK: begin
                if (fall_s) begin
                    cnt_d = '0;
                    if (!dat_sync_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        abort_s = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && dat_sync_q) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (fall_s) begin
                    cnt_d = '0;
                end else if (tmo_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        if (abort_s) begin
            error_d  = 1'b1;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
        end else begin
            error_d = 1'b0;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            buf_q    <= 10'd0;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign cmd_busy   = busy_q;
    assign cmd_done   = done_q;
    assign cmd_error  = error_q;

endmodule
